cla_nibble_serial_adder: RTL and testbench
==========================================

Name: cla_nibble_serial_adder

Overview:
- Sequential WIDTH-bit adder built around one 4-bit carry-lookahead slice.
- Processes one nibble per clock, LSB nibble first, and chains the carry through a register.
- Sits between operand-producing logic and result consumers on valid/ready handshakes.
- Trades latency for area against a full-width CLA.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIBBLES, WIDTH/4, derived; number of RUN cycles per operation; not user-overridable.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in to the LSB nibble.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, a+b+cin mod 2^WIDTH.
- cout  output  1  carry out of MSB nibble.

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry reg=0, nibble index=0.
- Reset in any state, including mid-RUN or DONE with an unconsumed result, aborts and discards the operation. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b, cin into operand regs, clear sum reg, set idx=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice adds nibble idx of A and B with the carry reg (cin on idx=0).
  - Write the slice sum to sum[4*idx+3:4*idx] and store the slice carry in the carry reg.
  - Increment idx. After the nibble with idx==NIBBLES-1, set cout to the slice carry and go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout hold stable while out_ready=0.
  - On out_ready, go to IDLE next cycle and drop out_valid.
- Latency: out_valid rises NIBBLES cycles after the accept edge (4 for WIDTH=16).
- Minimum initiation interval: NIBBLES+2 cycles (accept edge, NIBBLES RUN edges, release edge).
- in_valid and operand inputs are ignored whenever in_ready=0. No queuing.
- Operand registers are captured only on accept, so input changes during RUN have no effect.
- sum and cout retain the last result after release until the next accept clears sum.
- Overflow is not an error: the result wraps modulo 2^WIDTH, and cout carries the lost bit.
- The carry into each nibble is only the registered carry. No combinational path from a/b to sum/cout.

Decomposition:
- Package cla_pkg:
  - NIBBLE_W=4.
  - State enum typedef (IDLE, RUN, DONE).
  - Function to check WIDTH%4==0.
- Sub-module cla_4bit_slice:
  - Purely combinational 4-bit generate/propagate lookahead adder (a, b, cin -> sum, cout).
  - Instantiated once.
- All sequencing, handshake and indexing logic lives in the top.

Test Plan:
- 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0; out_valid high exactly 4 cycles after accept edge; in_ready=0 during RUN/DONE.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1 (carry rippled through all 4 registered nibble steps); also 0xFFFF+0x0000, cin=1 -> 0x0000, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, sum/cout stable. in_valid with 0x0001+0x0001 during the hold is ignored. After release, next result comes only from a new accept.
- Reset mid-RUN after 2 nibbles -> next cycle IDLE, out_valid=0, sum=0, cout=0, in_ready=1. Then 0x00FF+0x0F01, cin=0 -> 0x1000, cout=0.
- Back-to-back with out_ready tied 1 and in_valid held: second accept occurs 6 cycles after first. 0x8000+0x8000 -> 0x0000, cout=1; 0x7FFF+0x0001 -> 0x8000, cout=0.
- WIDTH=8 instance: 0xF0+0x10, cin=1 -> sum=0x01, cout=1, latency 2 cycles. WIDTH=6 fails elaboration.

Source files
------------

// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial carry-lookahead adder:
// nibble width, FSM state encoding and the WIDTH legality check.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // A usable operand width is a whole, non-zero number of nibbles.
  function automatic bit width_ok(input int width);
    return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The master side produces operands and consumes results; the adder is the slave.
interface cla_nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/cla_nibble_serial_adder_slice.sv
// Purely combinational 4-bit generate/propagate carry-lookahead adder.
// Every internal carry is a flat sum of products of g, p and the carry in,
// so there is no ripple inside the nibble.
module cla_4bit_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  // Lookahead carries from per-bit generate/propagate, then the sum bits.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = cin_i;
    c[1] = g[0] | (p[0] & cin_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin_i);
    sum_o  = p ^ c[NIBBLE_W-1:0];
    cout_o = c[NIBBLE_W];
  end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Sequential WIDTH-bit adder: one 4-bit lookahead slice is reused once per
// nibble, LSB nibble first, with the inter-nibble carry held in a register.
// Operands are captured on accept, so a/b never reach sum/cout combinationally.
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  cla_nibble_serial_adder_if.slave bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cla_nibble_serial_adder: WIDTH=%0d must be a multiple of 4 and at least 4", WIDTH);
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic                slice_cin;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  // Appending two zero bits to idx turns a nibble number into its bit offset.
  assign slice_a   = a_q[{idx_q, 2'b00} +: NIBBLE_W];
  assign slice_b   = b_q[{idx_q, 2'b00} +: NIBBLE_W];
  assign slice_cin = (idx_q == '0) ? cin_q : carry_q;

  cla_4bit_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (slice_cin),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  // Next-state logic: accept in IDLE, one nibble per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cin_d   = bus.cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: NIBBLE_W] = slice_sum;
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for the nibble-serial CLA adder: a table of directed
// additions on a 16-bit instance plus hand-written handshake sequences and
// a small 8-bit instance.
module tb_cla_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  cla_nibble_serial_adder_if #(.WIDTH(8))  bus8 ();

  cla_nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  cla_nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the 16-bit DUT idle; returns RUN cycles counted
  // from the accept edge and whether in_ready was seen high while busy.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic cin, output int latency,
                               output bit readySeen);
    bus16.in_valid = 1'b1;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a        = ~a;
    bus16.b        = ~b;
    bus16.cin      = ~cin;
    latency   = 0;
    readySeen = 1'b0;
    while (!bus16.out_valid && latency < 20) begin
      if (bus16.in_ready) readySeen = 1'b1;
      @(posedge clk);
      @(negedge clk);
      latency++;
    end
    if (bus16.in_ready) readySeen = 1'b1;
  endtask

  // Full transaction with out_ready already high; leaves the DUT idle.
  task automatic runVector(input vec_t v);
    int lat;
    bit rs;
    checkOutput($sformatf("%s in_ready before", v.tag), 32'(bus16.in_ready), 32'd1);
    applyStimulus(v.a, v.b, v.cin, lat, rs);
    checkOutput($sformatf("%s sum", v.tag), 32'(bus16.sum), 32'(v.sum));
    checkOutput($sformatf("%s cout", v.tag), 32'(bus16.cout), 32'(v.cout));
    checkOutput($sformatf("%s latency", v.tag), 32'(lat), 32'd4);
    checkOutput($sformatf("%s in_ready while busy", v.tag), 32'(rs), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  rs;
    bit  sawValid;
    int  firstAcc;
    int  secondAcc;
    bit  gotFirst;
    logic [15:0] firstSum;
    logic        firstCout;

    vecs[0] = '{"1234+4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{"FFFF+0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"FFFF+0000+1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{"ABCD+1111+1", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vecs[4] = '{"00FF+0F01", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{"7FFF+0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[6] = '{"8000+8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    rst             = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.cin       = 1'b0;
    bus16.out_ready = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.a          = '0;
    bus8.b          = '0;
    bus8.cin        = 1'b0;
    bus8.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("reset in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("reset sum", 32'(bus16.sum), 32'd0);
    checkOutput("reset cout", 32'(bus16.cout), 32'd0);
    checkOutput("reset w8 out_valid", 32'(bus8.out_valid), 32'd0);

    bus16.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i]);
    end

    // Reset after two nibbles: partial result must vanish, cout from the
    // previous 8000+8000 must be cleared too.
    bus16.in_valid = 1'b1;
    bus16.a        = 16'h1234;
    bus16.b        = 16'h4321;
    bus16.cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("midrun partial sum", 32'(bus16.sum), 32'h0055);
    checkOutput("midrun out_valid", 32'(bus16.out_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("abort out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("abort sum", 32'(bus16.sum), 32'd0);
    checkOutput("abort cout", 32'(bus16.cout), 32'd0);
    runVector(vecs[4]);

    // Backpressure: result must hold while the consumer stalls, and an
    // offered operand set during the stall must not be taken.
    bus16.out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, lat, rs);
    checkOutput("bp latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a        = 16'h0001;
      bus16.b        = 16'h0001;
      bus16.cin      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d out_valid", i), 32'(bus16.out_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d sum", i), 32'(bus16.sum), 32'h1010);
      checkOutput($sformatf("bp hold%0d cout", i), 32'(bus16.cout), 32'd0);
      checkOutput($sformatf("bp hold%0d in_ready", i), 32'(bus16.in_ready), 32'd0);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp release out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("bp release in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("bp retained sum", 32'(bus16.sum), 32'h1010);
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus16.out_valid) sawValid = 1'b1;
    end
    checkOutput("bp no phantom result", 32'(sawValid), 32'd0);

    // Back-to-back: in_valid held, out_ready tied high.
    bus16.in_valid = 1'b1;
    bus16.a        = 16'h8000;
    bus16.b        = 16'h8000;
    bus16.cin      = 1'b0;
    firstAcc  = -1;
    secondAcc = -1;
    gotFirst  = 1'b0;
    firstSum  = '0;
    firstCout = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (bus16.in_valid && bus16.in_ready) begin
        if (firstAcc < 0) firstAcc = t;
        else secondAcc = t;
      end
      if (bus16.out_valid && !gotFirst) begin
        gotFirst  = 1'b1;
        firstSum  = bus16.sum;
        firstCout = bus16.cout;
      end
      if (secondAcc >= 0) break;
      @(posedge clk);
      @(negedge clk);
      if (t == firstAcc) begin
        bus16.a = 16'h7FFF;
        bus16.b = 16'h0001;
      end
    end
    checkOutput("b2b first sum", 32'(firstSum), 32'h0000);
    checkOutput("b2b first cout", 32'(firstCout), 32'd1);
    checkOutput("b2b accept spacing", 32'(secondAcc - firstAcc), 32'd6);
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b second latency", 32'(lat), 32'd4);
    checkOutput("b2b second sum", 32'(bus16.sum), 32'h8000);
    checkOutput("b2b second cout", 32'(bus16.cout), 32'd0);

    // 8-bit instance: two RUN cycles.
    bus8.out_ready = 1'b1;
    checkOutput("w8 in_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid = 1'b1;
    bus8.a        = 8'hF0;
    bus8.b        = 8'h10;
    bus8.cin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.a        = 8'h00;
    bus8.b        = 8'h00;
    bus8.cin      = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checkOutput("w8 latency", 32'(lat), 32'd2);
    checkOutput("w8 sum", 32'(bus8.sum), 32'h01);
    checkOutput("w8 cout", 32'(bus8.cout), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
